// File: rtl/jpeg_pkg.sv
// Shared JPEG decode constants: table geometry, zigzag-to-natural index map and
// the saturating coefficient * quant multiply used by the dequantiser.
package jpeg_pkg;

    localparam int COEF_W      = 16;
    localparam int DQT_QUANT_W = 8;
    localparam int DQT_TABLES  = 4;
    localparam int PROD_W      = COEF_W + DQT_QUANT_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'((1 <<< (COEF_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_LO = -SAT_HI - PROD_W'(1);

    localparam logic [5:0] ZZ2NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz2nat(input logic [5:0] zz);
        return ZZ2NAT[zz];
    endfunction

    // Quant entries are unsigned, so zero-extend before the signed multiply.
    function automatic logic [COEF_W-1:0] sat_mul(input logic signed [COEF_W-1:0] coef,
                                                  input logic [DQT_QUANT_W-1:0]   q);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(coef) * $signed(PROD_W'(q));
        if (p > SAT_HI)
            return {1'b0, {(COEF_W-1){1'b1}}};
        else if (p < SAT_LO)
            return {1'b1, {(COEF_W-1){1'b0}}};
        else
            return p[COEF_W-1:0];
    endfunction

endpackage

// File: rtl/jpeg_dequant_qtable_ram.sv
// Quant table storage: one write port, one registered read port with enable.
// A read colliding with a write to the same address returns the old entry.
module jpeg_dequant_qtable_ram
    import jpeg_pkg::*;
#(
    parameter int QUANT_W = DQT_QUANT_W,
    parameter int ADDR_W  = 8
) (
    input  logic               clk_i,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [QUANT_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [QUANT_W-1:0] rdata
);

    logic [QUANT_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/jpeg_dequant.sv
// Two-stage dequantiser: S1 captures the beat and reads its quant entry,
// S2 holds the saturated product, natural-order index and EOB.
module jpeg_dequant
    import jpeg_pkg::*;
#(
    parameter int DATA_W     = COEF_W,
    parameter int QUANT_W    = DQT_QUANT_W,
    parameter int NUM_TABLES = DQT_TABLES
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          img_start_i,
    input  logic                          cfg_dqt_valid_i,
    input  logic [$clog2(NUM_TABLES)-1:0] cfg_dqt_table_i,
    input  logic [5:0]                    cfg_dqt_idx_i,
    input  logic [QUANT_W-1:0]            cfg_dqt_data_i,
    input  logic                          inport_valid_i,
    input  logic signed [DATA_W-1:0]      inport_data_i,
    input  logic [5:0]                    inport_idx_i,
    input  logic [$clog2(NUM_TABLES)-1:0] inport_qtable_i,
    input  logic                          inport_eob_i,
    output logic                          inport_accept_o,
    output logic                          outport_valid_o,
    output logic signed [DATA_W-1:0]      outport_data_o,
    output logic [5:0]                    outport_idx_o,
    output logic                          outport_eob_o,
    input  logic                          outport_accept_i
);

    localparam int TSEL_W = $clog2(NUM_TABLES);
    localparam int ADDR_W = TSEL_W + 6;

    logic [2:1]               vld_pipe;
    logic                     adv1, adv2, take;
    logic signed [DATA_W-1:0] s1_data, s2_data;
    logic [5:0]               s1_idx, s2_idx;
    logic                     s1_eob, s2_eob;
    logic [QUANT_W-1:0]       q_rdata;

    assign adv2            = ~vld_pipe[2] | outport_accept_i;
    assign adv1            = ~vld_pipe[1] | adv2;
    assign inport_accept_o = adv1 & ~img_start_i;
    assign take            = inport_valid_i & inport_accept_o;

    // Read is enabled by adv1 so a stalled S1 keeps the entry it already fetched.
    jpeg_dequant_qtable_ram #(
        .QUANT_W (QUANT_W),
        .ADDR_W  (ADDR_W)
    ) u_qtable (
        .clk_i (clk_i),
        .we    (cfg_dqt_valid_i),
        .waddr ({cfg_dqt_table_i, cfg_dqt_idx_i}),
        .wdata (cfg_dqt_data_i),
        .re    (adv1),
        .raddr ({inport_qtable_i, inport_idx_i}),
        .rdata (q_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_idx   <= '0;
            s1_eob   <= 1'b0;
            s2_data  <= '0;
            s2_idx   <= '0;
            s2_eob   <= 1'b0;
        end else if (img_start_i) begin
            vld_pipe <= '0;
            s2_eob   <= 1'b0;
        end else begin
            if (adv1) begin
                vld_pipe[1] <= take;
                s1_data     <= inport_data_i;
                s1_idx      <= inport_idx_i;
                s1_eob      <= inport_eob_i;
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                s2_eob      <= vld_pipe[1] & s1_eob;
                if (vld_pipe[1]) begin
                    s2_data <= sat_mul(s1_data, q_rdata);
                    s2_idx  <= zz2nat(s1_idx);
                end
            end
        end
    end

    assign outport_valid_o = vld_pipe[2];
    assign outport_data_o  = s2_data;
    assign outport_idx_o   = s2_idx;
    assign outport_eob_o   = s2_eob;

endmodule

// File: tb/tb_jpeg_dequant.sv
// Self-checking bench for jpeg_dequant: directed cases plus randomized traffic
// scored against a table/queue model of the dequantiser.
module tb_jpeg_dequant;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        img_start_i = 1'b0;
    logic        cfg_dqt_valid_i = 1'b0;
    logic [1:0]  cfg_dqt_table_i = '0;
    logic [5:0]  cfg_dqt_idx_i = '0;
    logic [7:0]  cfg_dqt_data_i = '0;
    logic        inport_valid_i = 1'b0;
    logic [15:0] inport_data_i = '0;
    logic [5:0]  inport_idx_i = '0;
    logic [1:0]  inport_qtable_i = '0;
    logic        inport_eob_i = 1'b0;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [15:0] outport_data_o;
    logic [5:0]  outport_idx_o;
    logic        outport_eob_o;
    logic        outport_accept_i = 1'b1;

    jpeg_dequant dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .img_start_i      (img_start_i),
        .cfg_dqt_valid_i  (cfg_dqt_valid_i),
        .cfg_dqt_table_i  (cfg_dqt_table_i),
        .cfg_dqt_idx_i    (cfg_dqt_idx_i),
        .cfg_dqt_data_i   (cfg_dqt_data_i),
        .inport_valid_i   (inport_valid_i),
        .inport_data_i    (inport_data_i),
        .inport_idx_i     (inport_idx_i),
        .inport_qtable_i  (inport_qtable_i),
        .inport_eob_i     (inport_eob_i),
        .inport_accept_o  (inport_accept_o),
        .outport_valid_o  (outport_valid_o),
        .outport_data_o   (outport_data_o),
        .outport_idx_o    (outport_idx_o),
        .outport_eob_o    (outport_eob_o),
        .outport_accept_i (outport_accept_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: quant tables, zigzag map built by walking the diagonals.
    typedef struct {
        logic [15:0] d;
        logic [5:0]  i;
        logic        e;
    } beat_t;

    logic [7:0] qt [4][64];
    int         zz_nat [64];
    beat_t      exp_q [$];
    int         n_out = 0;
    int         n_eob = 0;
    bit         done = 1'b0;

    function automatic logic [15:0] ref_mul(input logic [15:0] c, input logic [7:0] q);
        longint p;
        p = longint'($signed(c)) * longint'(q);
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return 16'(p);
    endfunction

    always @(negedge clk_i) begin
        beat_t b;
        if (!rst_i) begin
            exp_q.delete();
        end else begin
            if (outport_valid_o && outport_accept_i) begin
                n_out++;
                if (outport_eob_o) n_eob++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("sb_data", outport_data_o, b.d);
                    chk("sb_idx", outport_idx_o, b.i);
                    chk("sb_eob", outport_eob_o, b.e);
                end
            end
            if (img_start_i) begin
                chk("flush_acc", inport_accept_o, 32'd0);
                exp_q.delete();
            end else if (inport_valid_i && inport_accept_o) begin
                b.d = ref_mul(inport_data_i, qt[inport_qtable_i][inport_idx_i]);
                b.i = 6'(zz_nat[inport_idx_i]);
                b.e = inport_eob_i;
                exp_q.push_back(b);
            end
            if (cfg_dqt_valid_i)
                qt[cfg_dqt_table_i][cfg_dqt_idx_i] = cfg_dqt_data_i;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic dqt_wr(input int t, input int i, input int v);
        cfg_dqt_valid_i = 1'b1;
        cfg_dqt_table_i = 2'(t);
        cfg_dqt_idx_i   = 6'(i);
        cfg_dqt_data_i  = 8'(v);
        tick();
        cfg_dqt_valid_i = 1'b0;
    endtask

    task automatic send(input int c, input int zz, input int t, input bit eob);
        int n;
        n = 0;
        inport_valid_i  = 1'b1;
        inport_data_i   = 16'(c);
        inport_idx_i    = 6'(zz);
        inport_qtable_i = 2'(t);
        inport_eob_i    = eob;
        forever begin
            @(negedge clk_i);
            if (inport_accept_o) break;
            n++;
            if (n > 200) begin
                chk("acc_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick();
        inport_valid_i = 1'b0;
        inport_eob_i   = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [15:0] d, input logic [5:0] i);
        int n;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (outport_valid_o && outport_accept_i) break;
            n++;
            if (n > 20) break;
        end
        chk({tag, "_v"}, outport_valid_o, 32'd1);
        chk({tag, "_d"}, outport_data_o, d);
        chk({tag, "_i"}, outport_idx_o, i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, r, c, n0;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            for (int j = 0; j < 8; j++) begin
                r = (s % 2 == 1) ? j : 7 - j;
                c = s - r;
                if (c >= 0 && c < 8) begin
                    zz_nat[k] = r * 8 + c;
                    k++;
                end
            end
        end

        // reset state
        #12;
        chk("rst_valid", outport_valid_o, 32'd0);
        chk("rst_eob", outport_eob_o, 32'd0);
        chk("rst_data", outport_data_o, 32'd0);
        chk("rst_idx", outport_idx_o, 32'd0);
        #1 rst_i = 1'b1;
        tick();

        // table 0 all ones, tables 1..3 random
        for (int i = 0; i < 64; i++) dqt_wr(0, i, 1);
        for (int t = 1; t < 4; t++)
            for (int i = 0; i < 64; i++) dqt_wr(t, i, $urandom_range(0, 255));
        dqt_wr(0, 1, 2);

        // basic multiply, latency 2
        send(5, 1, 0, 0);
        @(negedge clk_i);
        chk("lat_s1_v", outport_valid_o, 32'd0);
        @(negedge clk_i);
        chk("lat_s2_v", outport_valid_o, 32'd1);
        chk("lat_s2_d", outport_data_o, 32'd10);
        chk("lat_s2_i", outport_idx_o, 32'd1);
        send(-3, 2, 0, 0);
        wait_out("neg", 16'hFFFD, 6'd8);

        // saturation boundaries
        dqt_wr(0, 0, 255);
        send(16'h7FFF, 0, 0, 0);
        wait_out("sat_max", 16'h7FFF, 6'd0);
        send(16'h8000, 0, 0, 0);
        wait_out("sat_min", 16'h8000, 6'd0);
        send(200, 0, 0, 0);
        wait_out("sat_200", 16'h7FFF, 6'd0);

        // zero quant entry
        dqt_wr(2, 9, 0);
        send(1234, 9, 2, 0);
        wait_out("q_zero", 16'h0000, 6'd24);
        repeat (3) tick();

        // backpressure stream
        n0 = n_out;
        fork
            begin
                for (int j = 0; j < 8; j++) send(j * 3 - 7, j + 10, 0, 0);
            end
            begin
                repeat (2) tick();
                outport_accept_i = 1'b0;
                repeat (5) @(negedge clk_i);
                chk("stall_acc", inport_accept_o, 32'd0);
                chk("stall_v", outport_valid_o, 32'd1);
                tick();
                outport_accept_i = 1'b1;
            end
        join
        repeat (4) tick();
        chk("stream_cnt", n_out - n0, 32'd8);

        // EOB block then next block
        n0 = n_eob;
        send(100, 3, 1, 0);
        send(-100, 4, 1, 0);
        send(7, 5, 1, 1);
        send(9, 0, 1, 0);
        repeat (4) tick();
        chk("eob_cnt", n_eob - n0, 32'd1);

        // table select and write/read collision
        dqt_wr(0, 5, 1);
        dqt_wr(3, 5, 7);
        send(4, 5, 0, 0);
        wait_out("tbl0", 16'd4, 6'd2);
        send(4, 5, 3, 0);
        wait_out("tbl3", 16'd28, 6'd2);
        cfg_dqt_valid_i = 1'b1;
        cfg_dqt_table_i = 2'd0;
        cfg_dqt_idx_i   = 6'd5;
        cfg_dqt_data_i  = 8'd9;
        send(4, 5, 0, 0);
        cfg_dqt_valid_i = 1'b0;
        wait_out("coll_old", 16'd4, 6'd2);
        send(4, 5, 0, 0);
        wait_out("coll_new", 16'd36, 6'd2);
        repeat (3) tick();

        // img_start flush with a simultaneous beat
        n0 = n_out;
        outport_accept_i = 1'b0;
        send(11, 1, 0, 0);
        send(12, 2, 0, 0);
        img_start_i     = 1'b1;
        inport_valid_i  = 1'b1;
        inport_data_i   = 16'd13;
        inport_idx_i    = 6'd3;
        tick();
        img_start_i    = 1'b0;
        inport_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_v", outport_valid_o, 32'd0);
        outport_accept_i = 1'b1;
        repeat (5) tick();
        chk("flush_cnt", n_out - n0, 32'd0);

        // async reset while stalled
        n0 = n_out;
        outport_accept_i = 1'b0;
        send(21, 6, 0, 0);
        send(22, 7, 0, 0);
        #3 rst_i = 1'b0;
        #1;
        chk("arst_v", outport_valid_o, 32'd0);
        chk("arst_d", outport_data_o, 32'd0);
        chk("arst_i", outport_idx_o, 32'd0);
        repeat (2) tick();
        rst_i = 1'b1;
        outport_accept_i = 1'b1;
        repeat (5) tick();
        chk("arst_cnt", n_out - n0, 32'd0);

        // randomized traffic with backpressure and live table writes
        n0 = n_out;
        done = 1'b0;
        fork
            begin
                for (int j = 0; j < 300; j++) begin
                    if ($urandom_range(0, 4) == 0) tick();
                    send($urandom, $urandom_range(0, 63), $urandom_range(0, 3),
                         $urandom_range(0, 7) == 0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    outport_accept_i = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 9) == 0) begin
                        cfg_dqt_valid_i = 1'b1;
                        cfg_dqt_table_i = 2'($urandom_range(0, 3));
                        cfg_dqt_idx_i   = 6'($urandom_range(0, 63));
                        cfg_dqt_data_i  = 8'($urandom_range(0, 255));
                    end else begin
                        cfg_dqt_valid_i = 1'b0;
                    end
                    tick();
                end
                cfg_dqt_valid_i  = 1'b0;
                outport_accept_i = 1'b1;
            end
        join
        repeat (6) tick();
        chk("rand_cnt", n_out - n0, 32'd300);
        chk("drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
